// File: rtl/truth_table_sweeper.sv
// Sweeps an N_IN-input combinational block through every input vector in
// ascending order, captures its output as a truth table and scores it against a latched reference.
module truth_table_sweeper #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [(2**N_IN)-1:0]    i_expected,
    output logic [N_IN-1:0]         o_vec_out,
    input  logic                    i_f_in,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_results_valid,
    output logic                    o_pass,
    output logic [(2**N_IN)-1:0]    o_table_out,
    output logic [N_IN:0]           o_mismatch_cnt,
    output logic [N_IN-1:0]         o_first_fail_idx
);

    localparam int unsigned V     = 2**N_IN;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned MM_W  = N_IN + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [N_IN-1:0]    r_idx;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [V-1:0]       r_expected;
    logic               r_fail_seen;
    logic [N_IN-1:0]    r_vec_out;
    logic               r_busy;
    logic               r_done;
    logic               r_results_valid;
    logic               r_pass;
    logic [V-1:0]       r_table;
    logic [MM_W-1:0]    r_mismatch_cnt;
    logic [N_IN-1:0]    r_first_fail_idx;

    logic               w_last_idx;
    logic               w_mismatch;

    assign w_last_idx = (r_idx == N_IN'(V - 1));
    assign w_mismatch = (i_f_in != r_expected[r_idx]);

    // Sweep sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_settle_cnt     <= '0;
            r_expected       <= '0;
            r_fail_seen      <= 1'b0;
            r_vec_out        <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_results_valid  <= 1'b0;
            r_pass           <= 1'b0;
            r_table          <= '0;
            r_mismatch_cnt   <= '0;
            r_first_fail_idx <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_abort && i_start) begin
                        r_expected       <= i_expected;
                        r_table          <= '0;
                        r_mismatch_cnt   <= '0;
                        r_first_fail_idx <= '0;
                        r_results_valid  <= 1'b0;
                        r_pass           <= 1'b0;
                        r_fail_seen      <= 1'b0;
                        r_idx            <= '0;
                        r_vec_out        <= '0;
                        r_settle_cnt     <= CNT_W'(SETTLE_CYC - 1);
                        r_busy           <= 1'b1;
                        r_state          <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (i_abort) begin
                        r_busy    <= 1'b0;
                        r_vec_out <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_settle_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (i_abort) begin
                        r_busy    <= 1'b0;
                        r_vec_out <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_table[r_idx] <= i_f_in;
                        if (w_mismatch) begin
                            r_mismatch_cnt <= r_mismatch_cnt + MM_W'(1);
                            if (!r_fail_seen) begin
                                r_first_fail_idx <= r_idx;
                                r_fail_seen      <= 1'b1;
                            end
                        end
                        if (w_last_idx) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx        <= r_idx + N_IN'(1);
                            r_vec_out    <= r_idx + N_IN'(1);
                            r_settle_cnt <= CNT_W'(SETTLE_CYC - 1);
                            r_state      <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    // Final mismatch count has landed by now, so pass is scored here.
                    r_results_valid <= 1'b1;
                    r_pass          <= (r_mismatch_cnt == '0);
                    r_busy          <= 1'b0;
                    r_vec_out       <= '0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_vec_out        = r_vec_out;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_results_valid  = r_results_valid;
    assign o_pass           = r_pass;
    assign o_table_out      = r_table;
    assign o_mismatch_cnt   = r_mismatch_cnt;
    assign o_first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: XOR and stuck-at models, restart,
// abort and mid-sweep reset scenarios with hand-computed expectations.
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] expected;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy;
    logic        done;
    logic        results_valid;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail_idx;

    logic        stuck0;
    int          n_vec;
    int          n_err;
    int          k;

    truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_abort          (abort),
        .i_expected       (expected),
        .o_vec_out        (vec_out),
        .i_f_in           (f_in),
        .o_busy           (busy),
        .o_done           (done),
        .o_results_valid  (results_valid),
        .o_pass           (pass),
        .o_table_out      (table_out),
        .o_mismatch_cnt   (mismatch_cnt),
        .o_first_fail_idx (first_fail_idx)
    );

    // Function block under test: 4-input parity, or output stuck at 0.
    assign f_in = stuck0 ? 1'b0 : ^vec_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_rv"},    32'(results_valid), 32'd0);
        chk({tag, "_pass"},  32'(pass), 32'd0);
        chk({tag, "_vec"},   32'(vec_out), 32'd0);
        chk({tag, "_table"}, 32'(table_out), 32'd0);
        chk({tag, "_mmcnt"}, 32'(mismatch_cnt), 32'd0);
        chk({tag, "_ffidx"}, 32'(first_fail_idx), 32'd0);
    endtask

    // Start pulse seen at edge t; negedge k then lies in cycle t+k.
    task automatic run_sweep(input string tag, input logic [15:0] exp_tbl, input bit trace);
        expected = exp_tbl;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        while (!done && k < 100) begin
            if (trace) chk({tag, "_vec_step"}, 32'(vec_out), 32'((k - 1) / 3));
            if (trace && k == 20) expected = 16'h0000;
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_cycle"}, 32'(k), 32'd49);
        chk({tag, "_done_vec"}, 32'(vec_out), 32'd15);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_vec"}, 32'(vec_out), 32'd0);
        chk({tag, "_rv"}, 32'(results_valid), 32'd1);
        expected = exp_tbl;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        k        = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 16'h0000;
        stuck0   = 1'b0;

        // 1: reset state, then idle with no start
        @(negedge clk);
        @(negedge clk);
        chk_idle_zero("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_idle_zero("idle");

        // 2: parity model against its correct table; expected port changed mid-sweep
        run_sweep("xor_ok", 16'h6996, 1'b1);
        chk("xor_ok_pass", 32'(pass), 32'd1);
        chk("xor_ok_mm", 32'(mismatch_cnt), 32'd0);
        chk("xor_ok_ff", 32'(first_fail_idx), 32'd0);
        chk("xor_ok_table", 32'(table_out), 32'h6996);

        // 3: reference 16'h4196 = 16'h6996 with bits 11 and 13 flipped
        run_sweep("xor_bad", 16'h4196, 1'b0);
        chk("xor_bad_pass", 32'(pass), 32'd0);
        chk("xor_bad_mm", 32'(mismatch_cnt), 32'd2);
        chk("xor_bad_ff", 32'(first_fail_idx), 32'd11);
        chk("xor_bad_table", 32'(table_out), 32'h6996);

        // 4: stuck-at-0 against all-ones: every index fails, count reaches V
        stuck0 = 1'b1;
        run_sweep("stuck", 16'hFFFF, 1'b0);
        chk("stuck_pass", 32'(pass), 32'd0);
        chk("stuck_mm", 32'(mismatch_cnt), 32'd16);
        chk("stuck_ff", 32'(first_fail_idx), 32'd0);
        chk("stuck_table", 32'(table_out), 32'h0000);
        stuck0 = 1'b0;

        // 5: start re-pulse ignored, abort at t+20
        expected = 16'h6996;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk("abort_rv_cleared", 32'(results_valid), 32'd0);
        while (k < 21) begin
            if (k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            if (k == 20) abort = 1'b1;
            if (k == 15) chk("abort_vec_k15", 32'(vec_out), 32'd4);
            chk("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
            k++;
        end
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vec", 32'(vec_out), 32'd0);
        chk("abort_rv", 32'(results_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        // vectors 0..5 were sampled before the abort; parity gives bits 1,2,4
        chk("abort_partial_table", 32'(table_out), 32'h0016);
        @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 32'd0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_vec", 32'(vec_out), 32'd0);

        // 6: reset in the middle of a sweep, then a clean full sweep
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_sweep("after_rst", 16'h6996, 1'b0);
        chk("after_rst_pass", 32'(pass), 32'd1);
        chk("after_rst_table", 32'(table_out), 32'h6996);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
